control_decode_stage: RTL and testbench
=======================================

CONTROL_DECODE_STAGE -- requirements
Module: control_decode_stage

Interface
REQ-001 Parameter PC_REG, default 4'd15, register index treated as the program counter for PCSrcE generation.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 InstrD  input  20  decode-stage instruction bits [31:12]: Cond[31:28], Op[27:26], Funct[25:20], Rn[19:16], Rd[15:12].
REQ-005 StallE  input  1  hold the E-stage control register.
REQ-006 FlushE  input  1  load a bubble (NOP) into the E-stage control register.
REQ-007 ImmSrcD  output  2  combinational immediate-extend select, D stage.
REQ-008 RegSrcD  output  2  combinational register-read-address select, D stage.
REQ-009 CondE  output  4  registered condition field.
REQ-010 FlagWriteE  output  2  registered flag-write enables: [1] for N,Z, [0] for C,V.
REQ-011 PCSrcE, RegWriteE, MemWriteE, BranchE, MemtoRegE, ALUSrcE  output  1 each  registered control bits.
REQ-012 ALUControlE  output  2  registered ALU op: 00 ADD, 01 SUB, 10 AND, 11 ORR.
REQ-013 UndefE  output  1  registered flag: the E-stage instruction is an undefined encoding and was converted to a NOP.

Function
REQ-014 Main decode on Op SHALL be:
- 00 (data-processing): RegWrite=1, ALUSrc=Funct[5], ImmSrc=00, RegSrc=00.
- 01 (memory): ALUSrc=1, ImmSrc=01; Funct[0]=0 (STR): MemWrite=1, RegWrite=0, RegSrc=10; Funct[0]=1 (LDR): RegWrite=1, MemtoReg=1, RegSrc=00.
- 10 (branch): Branch=1, ALUSrc=1, ImmSrc=10, RegSrc=01, RegWrite=0.
- 11: undefined.
REQ-015 For Op=00, cmd=Funct[4:1] SHALL map 0100->00, 0010->01, 0000->10, 1100->11; 1010 (CMP)->01 with RegWrite forced 0; any other cmd is undefined.
REQ-016 For Op=00, FlagWrite[1]=Funct[0] and FlagWrite[0]=Funct[0] & (ALUControl is 00 or 01); for Op other than 00, ALUControl=00 and FlagWrite=00.
REQ-017 PCSrc SHALL equal RegWrite & (Rd==PC_REG) after all forcing; Branch SHALL NOT contribute to PCSrc.
REQ-018 An encoding is undefined if Op=11, cmd is unsupported, or Cond=1111.
- Undefined encodings load into the E-stage register with Undef=1, Cond=1110, and every write enable (RegWrite, MemWrite, FlagWrite, PCSrc, Branch) = 0.
REQ-019 ImmSrcD and RegSrcD SHALL be purely combinational from InstrD with zero latency.
- For undefined encodings they SHALL be 00.
REQ-020 All E-stage outputs SHALL update exactly one cycle after InstrD is presented, when not stalled or flushed.
REQ-021 Priority per rising edge SHALL be reset > FlushE > StallE > load.
- FlushE with StallE loads a NOP.
- StallE alone holds every E-stage output unchanged.
REQ-022 The NOP/bubble value SHALL be: CondE=1110, all other E-stage outputs 0, UndefE=0.
REQ-023 CondE SHALL never leave the register as 1111, so that downstream condition evaluation never sees an undefined code.

Reset
REQ-024 While reset=1 at a rising edge, all E-stage outputs SHALL take the NOP value of REQ-022, regardless of StallE and FlushE.
REQ-025 Reset asserted mid-stall SHALL discard the held instruction; the first load after reset deasserts SHALL occur on the next unstalled edge.

Verification
REQ-026 InstrD=0xE0921 (ADDS R1,R2,R3), no stall -> next cycle RegWriteE=1, FlagWriteE=11, ALUControlE=00, ALUSrcE=0, PCSrcE=0, CondE=1110.
REQ-027 InstrD=0xE5801 (STR R1,[R0]) -> ImmSrcD=01 and RegSrcD=10 in the same cycle; next cycle MemWriteE=1, RegWriteE=0, ALUSrcE=1.
REQ-028 InstrD=0x0A000 (BEQ) -> ImmSrcD=10; next cycle BranchE=1, CondE=0000, PCSrcE=0, RegWriteE=0. InstrD=0xE04FF (SUB PC,PC,R2) -> PCSrcE=1, ALUControlE=01, FlagWriteE=00.
REQ-029 Load ADDS, then StallE=1 for 3 cycles while applying STR -> E outputs hold the ADDS values. FlushE=1 and StallE=1 together -> NOP on the next edge.
REQ-030 Undefined encodings -> next cycle UndefE=1, CondE=1110, all write enables 0:
- InstrD=0xF0921 (Cond=1111).
- InstrD=0xEC000 (Op=11).
- InstrD=0xE0221 (cmd=0001).
REQ-031 reset=1 during a loaded, stalled LDR -> outputs equal NOP on that edge; the held value is not restored after reset deasserts.

Source files
------------

// File: rtl/control_decode_stage_if.sv
// Decode-to-execute control bus: the D-stage instruction and pipeline controls go in,
// the D-stage extend/read selects and the registered E-stage control word come out.
interface control_decode_stage_if;
  logic [19:0] InstrD;
  logic        StallE;
  logic        FlushE;
  logic [1:0]  ImmSrcD;
  logic [1:0]  RegSrcD;
  logic [3:0]  CondE;
  logic [1:0]  FlagWriteE;
  logic        PCSrcE;
  logic        RegWriteE;
  logic        MemWriteE;
  logic        BranchE;
  logic        MemtoRegE;
  logic        ALUSrcE;
  logic [1:0]  ALUControlE;
  logic        UndefE;

  modport master (
    output InstrD, StallE, FlushE,
    input  ImmSrcD, RegSrcD, CondE, FlagWriteE, PCSrcE, RegWriteE, MemWriteE,
           BranchE, MemtoRegE, ALUSrcE, ALUControlE, UndefE
  );

  modport slave (
    input  InstrD, StallE, FlushE,
    output ImmSrcD, RegSrcD, CondE, FlagWriteE, PCSrcE, RegWriteE, MemWriteE,
           BranchE, MemtoRegE, ALUSrcE, ALUControlE, UndefE
  );
endinterface

// File: rtl/control_decode_stage.sv
// Decode-stage control unit: decodes InstrD and registers the control word into the E stage.
// Undefined encodings are squashed to a flagged NOP so no write enable can escape.
module control_decode_stage #(
  parameter logic [3:0] PC_REG = 4'd15
) (
  input  logic                   clk,
  input  logic                   reset,
  control_decode_stage_if.slave  bus
);

  typedef struct packed {
    logic [3:0] cond;
    logic [1:0] flag_write;
    logic       pc_src;
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic       mem_to_reg;
    logic       alu_src;
    logic [1:0] alu_control;
    logic       undef;
  } e_ctrl_t;

  localparam e_ctrl_t NOP_CTRL = {4'b1110, 11'b000_0000_0000};

  logic [3:0] w_cond;
  logic [1:0] w_op;
  logic [5:0] w_funct;
  logic [3:0] w_rd;
  logic       w_unused_rn;
  logic       w_undef_enc;
  logic       w_undef;
  logic [1:0] w_imm_src;
  logic [1:0] w_reg_src;
  e_ctrl_t    w_dec;
  e_ctrl_t    w_next;
  e_ctrl_t    r_e;

  assign w_cond      = bus.InstrD[19:16];
  assign w_op        = bus.InstrD[15:14];
  assign w_funct     = bus.InstrD[13:8];
  assign w_rd        = bus.InstrD[3:0];
  assign w_unused_rn = ^bus.InstrD[7:4];

  // Main and ALU decode of the raw fields, before undefined squashing
  always_comb begin
    w_dec       = NOP_CTRL;
    w_dec.cond  = w_cond;
    w_imm_src   = 2'b00;
    w_reg_src   = 2'b00;
    w_undef_enc = 1'b0;
    case (w_op)
      2'b00: begin
        w_dec.reg_write = 1'b1;
        w_dec.alu_src   = w_funct[5];
        case (w_funct[4:1])
          4'b0100: w_dec.alu_control = 2'b00;
          4'b0010: w_dec.alu_control = 2'b01;
          4'b0000: w_dec.alu_control = 2'b10;
          4'b1100: w_dec.alu_control = 2'b11;
          4'b1010: begin
            w_dec.alu_control = 2'b01;
            w_dec.reg_write   = 1'b0;
          end
          default: w_undef_enc = 1'b1;
        endcase
        // Only arithmetic ops produce meaningful C and V
        w_dec.flag_write = {w_funct[0], w_funct[0] & ~w_dec.alu_control[1]};
      end
      2'b01: begin
        w_dec.alu_src = 1'b1;
        w_imm_src     = 2'b01;
        if (w_funct[0]) begin
          w_dec.reg_write  = 1'b1;
          w_dec.mem_to_reg = 1'b1;
          w_reg_src        = 2'b00;
        end else begin
          w_dec.mem_write = 1'b1;
          w_reg_src       = 2'b10;
        end
      end
      2'b10: begin
        w_dec.branch  = 1'b1;
        w_dec.alu_src = 1'b1;
        w_imm_src     = 2'b10;
        w_reg_src     = 2'b01;
      end
      default: w_undef_enc = 1'b1;
    endcase
  end

  assign w_undef = w_undef_enc | (w_cond == 4'b1111);

  // Final E-stage word: undefined encodings become a flagged NOP with condition AL
  always_comb begin
    w_next = NOP_CTRL;
    if (w_undef) begin
      w_next.undef = 1'b1;
    end else begin
      w_next        = w_dec;
      w_next.pc_src = w_dec.reg_write & (w_rd == PC_REG);
    end
  end

  assign bus.ImmSrcD = w_undef ? 2'b00 : w_imm_src;
  assign bus.RegSrcD = w_undef ? 2'b00 : w_reg_src;

  // E-stage control register: reset > flush > stall > load
  always_ff @(posedge clk) begin
    if (reset) begin
      r_e <= NOP_CTRL;
    end else if (bus.FlushE) begin
      r_e <= NOP_CTRL;
    end else if (bus.StallE) begin
      r_e <= r_e;
    end else begin
      r_e <= w_next;
    end
  end

  assign bus.CondE       = r_e.cond;
  assign bus.FlagWriteE  = r_e.flag_write;
  assign bus.PCSrcE      = r_e.pc_src;
  assign bus.RegWriteE   = r_e.reg_write;
  assign bus.MemWriteE   = r_e.mem_write;
  assign bus.BranchE     = r_e.branch;
  assign bus.MemtoRegE   = r_e.mem_to_reg;
  assign bus.ALUSrcE     = r_e.alu_src;
  assign bus.ALUControlE = r_e.alu_control;
  assign bus.UndefE      = r_e.undef;

endmodule

// File: tb/tb_control_decode_stage.sv
// Self-checking bench for control_decode_stage: expected E-stage words are queued when
// an instruction is driven and compared after the clock edge that should load them.
module tb_control_decode_stage;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [14:0] sb[$];
  logic [14:0] exp_v;
  logic [14:0] got_v;

  control_decode_stage_if bus();

  control_decode_stage #(.PC_REG(4'd15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Field order: Cond, FlagWrite, PCSrc, RegWrite, MemWrite, Branch, MemtoReg, ALUSrc, ALUControl, Undef
  function automatic logic [14:0] mk(input logic [3:0] c, input logic [1:0] fw, input logic pc,
                                     input logic rw, input logic mw, input logic br, input logic m2r,
                                     input logic als, input logic [1:0] alu, input logic u);
    return {c, fw, pc, rw, mw, br, m2r, als, alu, u};
  endfunction

  function automatic logic [14:0] get_e();
    return {bus.CondE, bus.FlagWriteE, bus.PCSrcE, bus.RegWriteE, bus.MemWriteE, bus.BranchE,
            bus.MemtoRegE, bus.ALUSrcE, bus.ALUControlE, bus.UndefE};
  endfunction

  localparam logic [19:0] I_ADDS = 20'hE0921;
  localparam logic [19:0] I_STR  = 20'hE5801;
  localparam logic [19:0] I_LDR  = 20'hE5912;
  localparam logic [19:0] I_BEQ  = 20'h0A000;
  localparam logic [19:0] I_SUBP = 20'hE04FF;
  localparam logic [19:0] I_UND  = 20'hE0221;

  logic [14:0] e_nop, e_und, e_adds, e_str, e_ldr, e_beq, e_subp;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [19:0] ins, input logic st, input logic fl);
    bus.InstrD = ins;
    bus.StallE = st;
    bus.FlushE = fl;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(I_ADDS, 1'b0, 1'b0);
    sb.push_back(e_nop);
    step();
    exp_v = sb.pop_front(); got_v = get_e(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL reset got %h exp %h", got_v, exp_v); end
    reset = 1'b0;
  endtask

  task automatic test_dataproc();
    logic [19:0] ins [0:4];
    logic [14:0] ex  [0:4];
    ins = '{I_ADDS, I_SUBP, 20'hE0012, 20'hE3912, 20'hE150F};
    ex  = '{e_adds, e_subp,
            mk(4'b1110, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0),
            mk(4'b1110, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0),
            mk(4'b1110, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0)};
    for (int i = 0; i < 5; i++) begin
      drive(ins[i], 1'b0, 1'b0);
      sb.push_back(ex[i]);
      #1; checks++;
      if ({bus.ImmSrcD, bus.RegSrcD} !== 4'b0000) begin
        errors++; $display("FAIL dp_src[%0d] got %b exp 0000", i, {bus.ImmSrcD, bus.RegSrcD});
      end
      step();
      exp_v = sb.pop_front(); got_v = get_e(); checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL dp[%0d] got %h exp %h", i, got_v, exp_v); end
    end
  endtask

  task automatic test_mem_branch();
    logic [19:0] ins [0:4];
    logic [14:0] ex  [0:4];
    logic [3:0]  src [0:4];
    ins = '{I_STR, I_LDR, 20'hE591F, I_BEQ, 20'hEA00F};
    ex  = '{e_str, e_ldr,
            mk(4'b1110, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0),
            e_beq,
            mk(4'b1110, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0)};
    src = '{4'b0110, 4'b0100, 4'b0100, 4'b1001, 4'b1001};
    for (int i = 0; i < 5; i++) begin
      drive(ins[i], 1'b0, 1'b0);
      sb.push_back(ex[i]);
      #1; checks++;
      if ({bus.ImmSrcD, bus.RegSrcD} !== src[i]) begin
        errors++; $display("FAIL mb_src[%0d] got %b exp %b", i, {bus.ImmSrcD, bus.RegSrcD}, src[i]);
      end
      step();
      exp_v = sb.pop_front(); got_v = get_e(); checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL mb[%0d] got %h exp %h", i, got_v, exp_v); end
    end
  endtask

  task automatic test_undef();
    logic [19:0] ins [0:4];
    ins = '{20'hF0921, 20'hEC000, I_UND, 20'hE0C21, 20'hF5801};
    for (int i = 0; i < 5; i++) begin
      drive(ins[i], 1'b0, 1'b0);
      sb.push_back(e_und);
      #1; checks++;
      if ({bus.ImmSrcD, bus.RegSrcD} !== 4'b0000) begin
        errors++; $display("FAIL und_src[%0d] got %b exp 0000", i, {bus.ImmSrcD, bus.RegSrcD});
      end
      step();
      exp_v = sb.pop_front(); got_v = get_e(); checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL und[%0d] got %h exp %h", i, got_v, exp_v); end
    end
  endtask

  task automatic test_stall_flush();
    drive(I_ADDS, 1'b0, 1'b0);
    sb.push_back(e_adds);
    step();
    exp_v = sb.pop_front(); got_v = get_e(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL stall_load got %h exp %h", got_v, exp_v); end
    for (int i = 0; i < 3; i++) begin
      drive(I_STR, 1'b1, 1'b0);
      sb.push_back(e_adds);
      step();
      exp_v = sb.pop_front(); got_v = get_e(); checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL stall_hold[%0d] got %h exp %h", i, got_v, exp_v); end
    end
    drive(I_STR, 1'b1, 1'b1);
    sb.push_back(e_nop);
    step();
    exp_v = sb.pop_front(); got_v = get_e(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL flush_stall got %h exp %h", got_v, exp_v); end
    drive(I_STR, 1'b0, 1'b0);
  endtask

  task automatic test_reset_in_stall();
    drive(I_LDR, 1'b0, 1'b0);
    sb.push_back(e_ldr);
    step();
    exp_v = sb.pop_front(); got_v = get_e(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL rst_ldr got %h exp %h", got_v, exp_v); end
    reset = 1'b1;
    drive(I_ADDS, 1'b1, 1'b0);
    sb.push_back(e_nop);
    step();
    exp_v = sb.pop_front(); got_v = get_e(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL rst_stall got %h exp %h", got_v, exp_v); end
    reset = 1'b0;
    sb.push_back(e_nop);
    step();
    exp_v = sb.pop_front(); got_v = get_e(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL rst_no_restore got %h exp %h", got_v, exp_v); end
    drive(I_ADDS, 1'b0, 1'b0);
    sb.push_back(e_adds);
    step();
    exp_v = sb.pop_front(); got_v = get_e(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL rst_first_load got %h exp %h", got_v, exp_v); end
  endtask

  task automatic test_back_to_back();
    logic [19:0] ins [0:5];
    logic [14:0] ex  [0:5];
    logic [14:0] held;
    int k;
    logic st, fl;
    ins  = '{I_ADDS, I_STR, I_LDR, I_BEQ, I_SUBP, I_UND};
    ex   = '{e_adds, e_str, e_ldr, e_beq, e_subp, e_und};
    held = e_adds;
    for (int i = 0; i < 40; i++) begin
      k  = $urandom_range(0, 5);
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 7) == 0);
      drive(ins[k], st, fl);
      sb.push_back(fl ? e_nop : (st ? held : ex[k]));
      step();
      exp_v = sb.pop_front(); got_v = get_e(); checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL b2b[%0d] got %h exp %h", i, got_v, exp_v); end
      held = exp_v;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    e_nop  = mk(4'b1110, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    e_und  = mk(4'b1110, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
    e_adds = mk(4'b1110, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    e_str  = mk(4'b1110, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
    e_ldr  = mk(4'b1110, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0);
    e_beq  = mk(4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0);
    e_subp = mk(4'b1110, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
    reset  = 1'b1;
    drive(20'h00000, 1'b0, 1'b0);
    step();
    step();
    test_reset();
    test_dataproc();
    test_mem_branch();
    test_undef();
    test_stall_flush();
    test_reset_in_stall();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
